// File: rtl/pipe_scoreboard.sv
// Load-use scoreboard for an in-order RV32I pipe: per-register pending-load counters
// with ID hazard detection, plus a two-state data-memory wait FSM with timeout abort.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no data access outstanding (zero-wait accesses stay here)
// ST_WAIT | access issued, waiting for dmem_rvalid_ip or timeout
module pipe_scoreboard #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid_ip,
   input  logic [6:0]  id_opcode_ip,
   input  logic [4:0]  id_src1_addr_ip,
   input  logic [4:0]  id_src2_addr_ip,
   input  logic [4:0]  id_dest_addr_ip,
   input  logic        wb_load_valid_ip,
   input  logic [4:0]  wb_dest_addr_ip,
   input  logic        ex_kill_ip,
   input  logic        ex_kill_load_ip,
   input  logic [4:0]  ex_kill_dest_addr_ip,
   input  logic        lsu_mem_req_ip,
   input  logic        dmem_rvalid_ip,
   output logic        stall_op,
   output logic        mem_stall_op,
   output logic        issue_op,
   output logic        mem_timeout_op,
   output logic [31:0] load_pending_op
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

   typedef enum logic {ST_IDLE, ST_WAIT} mem_state_t;

   mem_state_t state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic [1:0] cnt_q [1:31];
   logic [1:0] cnt_d [1:31];

   logic        use_rs1, use_rs2, is_load;
   logic [31:0] pend_vec, full_vec;
   logic        hazard, timeout_hit, mem_stall_int, stall_int, issue_int;

   // ---------------------------------------------------------------- decode
   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      is_load = (id_opcode_ip == OPC_LOAD);
      case (id_opcode_ip)
         OPC_OP, OPC_STORE, OPC_BRANCH: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         OPC_OPIMM, OPC_LOAD, OPC_JALR: use_rs1 = 1'b1;
         OPC_LUI, OPC_AUIPC, OPC_JAL:   use_rs1 = 1'b0;
         default:                       use_rs1 = 1'b0;
      endcase
   end

   // x0 has no counter, so bit 0 of both vectors stays low
   always_comb begin
      pend_vec = '0;
      full_vec = '0;
      for (int r = 1; r < 32; r++) begin
         pend_vec[r] = (cnt_q[r] != 2'd0);
         full_vec[r] = (cnt_q[r] == 2'd3);
      end
   end

   always_comb begin
      hazard = id_valid_ip &
               ((use_rs1 & pend_vec[id_src1_addr_ip]) |
                (use_rs2 & pend_vec[id_src2_addr_ip]) |
                (is_load & full_vec[id_dest_addr_ip]));
   end

   // ---------------------------------------------------------------- memory FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign timeout_hit = (state_q == ST_WAIT) & ~dmem_rvalid_ip & (wait_cnt_q == WAIT_LIMIT);

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (lsu_mem_req_ip & ~dmem_rvalid_ip) begin
               state_d    = ST_WAIT;
               wait_cnt_d = 8'd0;
            end
         end
         ST_WAIT: begin
            if (dmem_rvalid_ip | timeout_hit) begin
               state_d    = ST_IDLE;
               wait_cnt_d = 8'd0;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   // the abort cycle itself releases the pipe, hence no stall while timeout_hit
   always_comb begin
      mem_stall_int = 1'b0;
      case (state_q)
         ST_IDLE: mem_stall_int = lsu_mem_req_ip & ~dmem_rvalid_ip;
         ST_WAIT: mem_stall_int = ~dmem_rvalid_ip & ~timeout_hit;
         default: mem_stall_int = 1'b0;
      endcase
      stall_int       = hazard | mem_stall_int;
      issue_int       = id_valid_ip & ~stall_int & ~ex_kill_ip;
      mem_stall_op    = mem_stall_int & ~reset;
      stall_op        = stall_int & ~reset;
      issue_op        = issue_int & ~reset;
      mem_timeout_op  = timeout_hit & ~reset;
      load_pending_op = reset ? 32'd0 : pend_vec;
   end

   // ---------------------------------------------------------------- counters
   always_comb begin
      logic       inc_hit, wb_hit, kill_hit;
      logic [2:0] sum_v, dec_v, diff_v;
      inc_hit  = 1'b0;
      wb_hit   = 1'b0;
      kill_hit = 1'b0;
      sum_v    = 3'd0;
      dec_v    = 3'd0;
      diff_v   = 3'd0;
      for (int r = 1; r < 32; r++) begin
         inc_hit  = issue_int & is_load & (id_dest_addr_ip == 5'(r));
         wb_hit   = wb_load_valid_ip & (wb_dest_addr_ip == 5'(r));
         kill_hit = ex_kill_ip & ex_kill_load_ip & (ex_kill_dest_addr_ip == 5'(r));
         sum_v    = {1'b0, cnt_q[r]} + {2'b00, inc_hit};
         dec_v    = {2'b00, wb_hit} + {2'b00, kill_hit};
         diff_v   = sum_v - dec_v;
         // underflow is a protocol error upstream; clamp rather than wrap
         if (dec_v > sum_v)
            cnt_d[r] = 2'd0;
         else if (diff_v > 3'd3)
            cnt_d[r] = 2'd3;
         else
            cnt_d[r] = diff_v[1:0];
      end
   end

   always_ff @(posedge clk) begin
      for (int r = 1; r < 32; r++) begin
         if (reset)
            cnt_q[r] <= 2'd0;
         else
            cnt_q[r] <= cnt_d[r];
      end
   end

endmodule
